// File: rtl/src_ctrl_pkg.sv
// src_ctrl_pkg: shared state codes, strobe bundle and latency helper for the
// sample-rate-converter control sequencer. Honours macro SRC_CTRL_ERR_EN.
package src_ctrl_pkg;

    localparam logic [2:0] ST_ALLOC_C = 3'b000;
    localparam logic [2:0] ST_INIT_C  = 3'b001;
    localparam logic [2:0] ST_CONV_C  = 3'b010;
    localparam logic [2:0] ST_RES_C   = 3'b011;
    localparam logic [2:0] ST_ERR_C   = 3'b100;
    localparam logic [2:0] ST_OUT_C   = 3'b101;
    localparam logic [2:0] ST_NEW_C   = 3'b110;
    localparam logic [2:0] ST_NEXT_C  = 3'b111;

    typedef enum logic [2:0] {
        ST_ALLOC = ST_ALLOC_C,
        ST_INIT  = ST_INIT_C,
        ST_CONV  = ST_CONV_C,
        ST_RES   = ST_RES_C,
        ST_ERR   = ST_ERR_C,
        ST_OUT   = ST_OUT_C,
        ST_NEW   = ST_NEW_C,
        ST_NEXT  = ST_NEXT_C
    } state_e;

`ifdef SRC_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Datapath strobes driven by the decoder.
    typedef struct packed {
        logic pc_clr;
        logic pc_incr;
        logic fetch;
        logic h_init;
        logic a_init;
        logic cnt;
        logic res_err;
        logic rf_rw;
        logic get_reg;
        logic new_in;
        logic new_out;
    } strobe_t;

    // Cycles spent on one channel with the output never stalled.
    function automatic int unsigned chan_latency(input int unsigned num_taps, input bit err_en);
        int unsigned lat;
        if (err_en) begin
            lat = num_taps + 32'd6;
        end else begin
            lat = num_taps + 32'd5;
        end
        return lat;
    endfunction

endpackage

// File: rtl/src_ctrl_decode.sv
// src_ctrl_decode: combinational map from sequencer state and input handshake
// to the eleven datapath strobes. Macro SRC_CTRL_ERR_EN adds the ERR decode.
module src_ctrl_decode
    import src_ctrl_pkg::*;
(
    input  state_e  state_i,
    input  logic    en_i,
    input  logic    in_valid_i,
    output strobe_t strobe_o
);

    // Decode the strobes of the current state; all quiet while disabled (reset).
    always_comb begin
        strobe_o = '0;
        if (en_i) begin
            case (state_i)
                ST_NEW: begin
                    if (in_valid_i) begin
                        strobe_o.pc_clr  = 1'b1;
                        strobe_o.rf_rw   = 1'b1;
                        strobe_o.get_reg = 1'b1;
                        strobe_o.new_in  = 1'b1;
                    end else begin
                        strobe_o = '0;
                    end
                end
                ST_ALLOC: begin
                    strobe_o.fetch  = 1'b1;
                    strobe_o.h_init = 1'b1;
                end
                ST_INIT: begin
                    strobe_o.a_init  = 1'b1;
                    strobe_o.get_reg = 1'b1;
                end
                ST_CONV: begin
                    strobe_o.cnt = 1'b1;
                end
                ST_RES: begin
                    strobe_o.res_err = 1'b1;
                    strobe_o.rf_rw   = 1'b1;
                end
`ifdef SRC_CTRL_ERR_EN
                ST_ERR: begin
                    strobe_o.rf_rw = 1'b1;
                end
`endif
                ST_OUT: begin
                    strobe_o.new_out = 1'b1;
                end
                ST_NEXT: begin
                    strobe_o.pc_incr = 1'b1;
                end
                default: begin
                    strobe_o = '0;
                end
            endcase
        end else begin
            strobe_o = '0;
        end
    end

endmodule

// File: rtl/src_ctrl_seq.sv
// src_ctrl_seq: N-tap, M-channel control sequencer for the sample-rate
// converter. Owns state, tap and channel counters; strobes are decoded
// combinationally. Macro SRC_CTRL_ERR_EN enables the ERR write-back state.
module src_ctrl_seq
    import src_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = 16,
    parameter int NUM_CH   = 2,
    parameter int TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pc_clr,
    output logic             pc_incr,
    output logic             fetch,
    output logic             h_init,
    output logic             a_init,
    output logic             cnt,
    output logic             res_err,
    output logic             rf_rw,
    output logic             get_reg,
    output logic             new_in,
    output logic             new_out,
    output logic [TAP_W-1:0] tap_idx,
    output logic [CH_W-1:0]  ch_idx,
    output logic             busy
);

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    state_e           state_q;
    state_e           state_eff_s;
    logic [TAP_W-1:0] tap_q;
    logic [CH_W-1:0]  ch_q;
    strobe_t          strobe_s;

    // Without the ERR state its code is dead; fold it onto NEW so it recovers.
    always_comb begin
        state_eff_s = state_q;
`ifndef SRC_CTRL_ERR_EN
        if (state_q == ST_ERR) begin
            state_eff_s = ST_NEW;
        end else begin
            state_eff_s = state_q;
        end
`endif
    end

    // Sequencer state, tap counter and channel counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NEW;
            tap_q   <= '0;
            ch_q    <= '0;
        end else begin
            case (state_eff_s)
                ST_NEW: begin
                    if (in_valid) begin
                        ch_q    <= '0;
                        state_q <= ST_ALLOC;
                    end else begin
                        state_q <= ST_NEW;
                    end
                end
                ST_ALLOC: begin
                    state_q <= ST_INIT;
                end
                ST_INIT: begin
                    tap_q   <= '0;
                    state_q <= ST_CONV;
                end
                ST_CONV: begin
                    if (tap_q == TAP_LAST) begin
                        state_q <= ST_RES;
                    end else begin
                        tap_q <= tap_q + TAP_W'(1);
                    end
                end
                ST_RES: begin
`ifdef SRC_CTRL_ERR_EN
                    state_q <= ST_ERR;
`else
                    state_q <= ST_OUT;
`endif
                end
`ifdef SRC_CTRL_ERR_EN
                ST_ERR: begin
                    state_q <= ST_OUT;
                end
`endif
                ST_OUT: begin
                    if (out_ready) begin
                        state_q <= ST_NEXT;
                    end else begin
                        state_q <= ST_OUT;
                    end
                end
                ST_NEXT: begin
                    if (ch_q == CH_LAST) begin
                        ch_q    <= '0;
                        state_q <= ST_NEW;
                    end else begin
                        ch_q    <= ch_q + CH_W'(1);
                        state_q <= ST_ALLOC;
                    end
                end
                default: begin
                    state_q <= ST_NEW;
                end
            endcase
        end
    end

    src_ctrl_decode u_decode (
        .state_i    (state_eff_s),
        .en_i       (!rst),
        .in_valid_i (in_valid),
        .strobe_o   (strobe_s)
    );

    // Handshake, status and index outputs; everything forced low while in reset.
    always_comb begin
        in_ready  = !rst && (state_eff_s == ST_NEW);
        busy      = !rst && (state_eff_s != ST_NEW);
        out_valid = !rst && (state_eff_s == ST_OUT);
        if (!rst && (state_eff_s == ST_CONV)) begin
            tap_idx = tap_q;
        end else begin
            tap_idx = '0;
        end
        if (rst) begin
            ch_idx = '0;
        end else begin
            ch_idx = ch_q;
        end
    end

    assign pc_clr  = strobe_s.pc_clr;
    assign pc_incr = strobe_s.pc_incr;
    assign fetch   = strobe_s.fetch;
    assign h_init  = strobe_s.h_init;
    assign a_init  = strobe_s.a_init;
    assign cnt     = strobe_s.cnt;
    assign res_err = strobe_s.res_err;
    assign rf_rw   = strobe_s.rf_rw;
    assign get_reg = strobe_s.get_reg;
    assign new_in  = strobe_s.new_in;
    assign new_out = strobe_s.new_out;

endmodule
